// File: rtl/mem_read_responder_pkg.sv
// ---------------------------------------------------------------------------
// mem_read_responder_pkg
//
// Shared constants for the cache fill path. The cache fill FSM and the memory
// responder both import this package so that they agree on port widths, read
// latency and block size.
//
//   MEM_ADDR_W  : byte address width of the request port
//   MEM_DATA_W  : word width
//   MEM_LATENCY : cycles from read request to data_valid
//   BLOCK_WORDS : words per cache block fill
// ---------------------------------------------------------------------------
package mem_read_responder_pkg;

    localparam int MEM_ADDR_W  = 16;
    localparam int MEM_DATA_W  = 16;
    localparam int MEM_LATENCY = 4;
    localparam int BLOCK_WORDS = 8;

endpackage

// File: rtl/mem_read_responder_latency_pipe.sv
// ---------------------------------------------------------------------------
// latency_pipe
//
// Fixed-depth shift register that carries a read response from the cycle it
// was sampled out of the array to the cycle it is presented. Each stage holds
// one packed word whose most significant bit is the stage valid flag.
// Reset clears every stage, which discards any reads still in flight.
//
// Ports:
//   clk       : system clock
//   rst       : synchronous active-high clear of all stages
//   stage_in  : word loaded into stage 1 every cycle (MSB = valid)
//   stage_out : contents of the last stage
//   any_valid : OR of all stage valid flags
// ---------------------------------------------------------------------------
module latency_pipe
    import mem_read_responder_pkg::*;
#(
    parameter int WIDTH = 1 + MEM_ADDR_W + MEM_DATA_W,
    parameter int DEPTH = MEM_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] stage_in,
    output logic [WIDTH-1:0] stage_out,
    output logic             any_valid
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Every stage is cleared on reset so the outputs also read back as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= stage_in;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign stage_out = stages[DEPTH-1];

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stages[i][WIDTH-1];
        end
    end

endmodule

// File: rtl/mem_read_responder.sv
// ---------------------------------------------------------------------------
// mem_read_responder
//
// Memory-side responder for the cache fill protocol. Owns the word storage
// array and answers read requests through a fixed-latency pipeline; one
// request (read or write) is accepted every cycle with no backpressure.
//
// Ports:
//   clk        : system clock, all state updates on the rising edge
//   rst        : synchronous active-high reset; clears in-flight reads,
//                storage contents are kept; requests in a reset cycle are
//                ignored
//   enable     : request present this cycle
//   wr         : 1 = write, 0 = read (qualified by enable)
//   addr       : byte address, addr[0] ignored
//   data_in    : write data
//   data_out   : read data, meaningful while data_valid = 1
//   data_valid : one-cycle strobe per returned read word
//   data_addr  : word-aligned address of the returned word
//   busy       : 1 while any read is in flight
// ---------------------------------------------------------------------------
module mem_read_responder
    import mem_read_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_W,
    parameter int DATA_WIDTH = MEM_DATA_W,
    parameter int LATENCY    = MEM_LATENCY,
    parameter int MEM_WORDS  = 32768
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic                  busy
);

    localparam int IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int STAGE_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [IDX_W-1:0]      mem_idx;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  rd_req;
    logic [STAGE_W-1:0]    pipe_in;
    logic [STAGE_W-1:0]    pipe_out;

    // Word index wraps modulo the array depth, so oversized addresses alias
    // onto the low words instead of falling off the end of the array.
    assign mem_idx   = IDX_W'(32'(addr[ADDR_WIDTH-1:1]) % 32'(MEM_WORDS));
    assign word_addr = addr & ~ADDR_WIDTH'(1);
    assign rd_req    = enable & ~wr;

    // The array is read combinationally and captured by stage 1 at the same
    // edge a write would land, so a read never sees a write from its own edge.
    assign pipe_in = {rd_req, word_addr, mem[mem_idx]};

    // Storage is deliberately not reset; a write presented during reset is
    // dropped.
    always_ff @(posedge clk) begin
        if (!rst && enable && wr) begin
            mem[mem_idx] <= data_in;
        end
    end

    latency_pipe #(
        .WIDTH (STAGE_W),
        .DEPTH (LATENCY)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .stage_in  (pipe_in),
        .stage_out (pipe_out),
        .any_valid (busy)
    );

    assign {data_valid, data_addr, data_out} = pipe_out;

endmodule

// File: tb/tb_mem_read_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_read_responder
//
// Directed bench for mem_read_responder. Each read issued pushes its expected
// word, address and return cycle into a queue; a monitor on the falling edge
// pops and compares whenever data_valid is seen. A second instance with a
// 16-word array exercises address wrap.
// ---------------------------------------------------------------------------
module tb_mem_read_responder;
    import mem_read_responder_pkg::*;

    localparam int LAT = MEM_LATENCY;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, wr;
    logic [15:0] addr, data_in;
    logic [15:0] data_out, data_addr;
    logic        data_valid, busy;

    logic        s_enable, s_wr;
    logic [15:0] s_addr, s_data_in;
    logic [15:0] s_data_out, s_data_addr;
    logic        s_data_valid, s_busy;

    int   cyc           = 0;
    int   checks_total  = 0;
    int   checks_passed = 0;
    exp_t main_q[$];
    exp_t small_q[$];

    mem_read_responder #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .LATENCY    (LAT),
        .MEM_WORDS  (32768)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_addr  (data_addr),
        .busy       (busy)
    );

    mem_read_responder #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .LATENCY    (LAT),
        .MEM_WORDS  (16)
    ) dut_small (
        .clk        (clk),
        .rst        (rst),
        .enable     (s_enable),
        .wr         (s_wr),
        .addr       (s_addr),
        .data_in    (s_data_in),
        .data_out   (s_data_out),
        .data_valid (s_data_valid),
        .data_addr  (s_data_addr),
        .busy       (s_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks_total++;
        if (actual === required) checks_passed++;
        else $display("[TB] FAIL %s at cycle %0d: got 0x%0h, required 0x%0h",
                      name, cyc, actual, required);
    endtask

    // Drives one cycle of stimulus to either instance, records expected reads,
    // then optionally checks busy / idle outputs mid-cycle.
    task automatic applyStimulus(input bit to_small, input logic r, e, w,
                                 input logic [15:0] a, d, exp_rd,
                                 input int exp_busy, input bit chk_idle);
        exp_t item;
        rst = r;
        if (to_small) begin
            enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
            s_enable = e; s_wr = w; s_addr = a; s_data_in = d;
        end else begin
            enable = e; wr = w; addr = a; data_in = d;
            s_enable = 1'b0; s_wr = 1'b0; s_addr = '0; s_data_in = '0;
        end
        if (r) begin
            while (main_q.size() > 0 && main_q[$].cyc > cyc) void'(main_q.pop_back());
            while (small_q.size() > 0 && small_q[$].cyc > cyc) void'(small_q.pop_back());
        end else if (e && !w) begin
            item.addr = a & 16'hFFFE;
            item.data = exp_rd;
            item.cyc  = cyc + LAT;
            if (to_small) small_q.push_back(item);
            else          main_q.push_back(item);
        end
        @(negedge clk);
        if (exp_busy >= 0) checkOutput("busy", 32'(busy), 32'(exp_busy));
        if (chk_idle) begin
            checkOutput("idle_data_valid", 32'(data_valid), 32'(0));
            checkOutput("idle_data_out",   32'(data_out),   32'(0));
            checkOutput("idle_data_addr",  32'(data_addr),  32'(0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doWrite(input logic [15:0] a, d);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, a, d, 16'h0, -1, 1'b0);
    endtask

    task automatic doRead(input logic [15:0] a, exp_rd, input int exp_busy);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, a, 16'h0, exp_rd, exp_busy, 1'b0);
    endtask

    task automatic doIdle(input int exp_busy);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, exp_busy, 1'b0);
    endtask

    task automatic doSmallWrite(input logic [15:0] a, d);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, a, d, 16'h0, -1, 1'b0);
    endtask

    task automatic doSmallRead(input logic [15:0] a, exp_rd);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, a, 16'h0, exp_rd, -1, 1'b0);
    endtask

    // Main instance monitor.
    always @(negedge clk) begin
        exp_t e;
        while (main_q.size() > 0 && main_q[0].cyc < cyc) begin
            checks_total++;
            $display("[TB] FAIL main_missing_valid at cycle %0d: no response, required data 0x%0h addr 0x%0h in cycle %0d",
                     cyc, main_q[0].data, main_q[0].addr, main_q[0].cyc);
            void'(main_q.pop_front());
        end
        if (data_valid === 1'b1) begin
            if (main_q.size() == 0) begin
                checks_total++;
                $display("[TB] FAIL main_unexpected_valid at cycle %0d: got data 0x%0h addr 0x%0h, required no response",
                         cyc, data_out, data_addr);
            end else begin
                e = main_q.pop_front();
                checkOutput("main_cycle", 32'(cyc),   32'(e.cyc));
                checkOutput("main_data",  32'(data_out),  32'(e.data));
                checkOutput("main_addr",  32'(data_addr), 32'(e.addr));
            end
        end
    end

    // Small (wrapping) instance monitor.
    always @(negedge clk) begin
        exp_t e;
        while (small_q.size() > 0 && small_q[0].cyc < cyc) begin
            checks_total++;
            $display("[TB] FAIL small_missing_valid at cycle %0d: no response, required data 0x%0h addr 0x%0h in cycle %0d",
                     cyc, small_q[0].data, small_q[0].addr, small_q[0].cyc);
            void'(small_q.pop_front());
        end
        if (s_data_valid === 1'b1) begin
            if (small_q.size() == 0) begin
                checks_total++;
                $display("[TB] FAIL small_unexpected_valid at cycle %0d: got data 0x%0h addr 0x%0h, required no response",
                         cyc, s_data_out, s_data_addr);
            end else begin
                e = small_q.pop_front();
                checkOutput("small_cycle", 32'(cyc),         32'(e.cyc));
                checkOutput("small_data",  32'(s_data_out),  32'(e.data));
                checkOutput("small_addr",  32'(s_data_addr), 32'(e.addr));
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, required completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset for two cycles, then three idle cycles with outputs at zero.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, -1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 0, 1'b1);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 0, 1'b1);

        // Single write then read.
        doWrite(16'h0010, 16'hBEEF);
        doRead(16'h0010, 16'hBEEF, 0);
        for (int i = 0; i < 4; i++) doIdle(1);
        doIdle(0);

        // Block fill: preload then eight back-to-back reads.
        for (int i = 0; i < BLOCK_WORDS; i++)
            doWrite(16'h0100 + 16'(2 * i), 16'h1000 + 16'(i));
        for (int i = 0; i < BLOCK_WORDS; i++)
            doRead(16'h0100 + 16'(2 * i), 16'h1000 + 16'(i), (i == 0) ? 0 : 1);
        for (int i = 0; i < 6; i++) doIdle((i < LAT) ? 1 : 0);

        // Read, write same address, read again.
        doWrite(16'h0020, 16'h1111);
        doRead(16'h0020, 16'h1111, -1);
        doWrite(16'h0020, 16'h2222);
        doRead(16'h0020, 16'h2222, -1);
        for (int i = 0; i < 6; i++) doIdle(-1);

        // Reset in the middle of a read burst.
        doWrite(16'h0040, 16'hA0A0);
        doWrite(16'h0042, 16'hA1A1);
        doWrite(16'h0044, 16'hA2A2);
        doWrite(16'h0046, 16'hA3A3);
        doRead(16'h0040, 16'hA0A0, -1);
        doRead(16'h0042, 16'hA1A1, -1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0044, 16'h0, 16'h0, -1, 1'b0);
        doRead(16'h0046, 16'hA3A3, 0);
        for (int i = 0; i < 4; i++) doIdle(1);
        doIdle(0);

        // A write presented during reset must be dropped.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0046, 16'hDEAD, 16'h0, -1, 1'b0);
        doRead(16'h0046, 16'hA3A3, 0);
        for (int i = 0; i < 6; i++) doIdle(-1);

        // Odd byte addresses map to the same word; data_addr is aligned.
        doWrite(16'h0031, 16'h5A5A);
        doRead(16'h0030, 16'h5A5A, -1);
        doWrite(16'h0033, 16'h0101);
        doRead(16'h0033, 16'h0101, -1);
        for (int i = 0; i < 6; i++) doIdle(-1);

        // Address wrap on the 16-word instance.
        doSmallWrite(16'h0000, 16'h7777);
        doSmallRead(16'h0020, 16'h7777);
        doSmallWrite(16'h0022, 16'h3333);
        doSmallRead(16'h0002, 16'h3333);
        for (int i = 0; i < 6; i++) doIdle(-1);

        checkOutput("small_busy_idle",   32'(s_busy),          32'(0));
        checkOutput("main_queue_empty",  32'(main_q.size()),  32'(0));
        checkOutput("small_queue_empty", 32'(small_q.size()), 32'(0));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
